eth_tx_pkt_buf: RTL and testbench
=================================

// Module: eth_tx_pkt_buf
// PURPOSE
//  Transmit packet buffer that sits directly upstream of eth_ctrl.
//  - Accepts whole UDP payloads from the PS-side AXI-Stream (8-bit) and stores them.
//  - Commits a packet only when its tlast beat is accepted.
//  - Presents each committed packet to eth_ctrl as a first-word-fall-through (FWFT) byte stream:
//    2-byte length header, LSB first, then the payload bytes.
// PARAMETERS
//  ADDR_W    11    payload RAM address width; DEPTH = 2**ADDR_W bytes (<=4096, distributed RAM)
//  PKT_W     3     length-FIFO address width; MAX_PKTS = 2**PKT_W committed packets
//  MAX_LEN   1472  largest accepted payload in bytes; longer packets are dropped
// PORTS
//  clk            in   1       system clock
//  rst            in   1       asynchronous reset, active-high
//  s_axis_tdata   in   8       payload byte from PS
//  s_axis_tvalid  in   1       byte valid
//  s_axis_tlast   in   1       last byte of packet
//  s_axis_tready  out  1       buffer accepts byte
//  tx_tvalid      out  1       complete packet ready; header LSB on tx_data
//  tx_req         in   1       pop current byte (FWFT)
//  tx_data        out  8       current head byte
//  pkt_cnt        out  PKT_W+1 committed, not fully read packets
//  drop_cnt       out  16      dropped packets, saturating at 16'hFFFF
//  tx_underrun    out  1       sticky: tx_req seen with no byte available
// BEHAVIOUR
//  Reset
//  - While rst=1, all outputs are 0: tready, tx_tvalid, tx_data, counters, tx_underrun.
//  - Pointers, the length FIFO and the read FSM are cleared.
//  - A packet that was partially written or partially read when reset asserts is discarded.
//  Write side
//  - A beat is accepted when s_axis_tvalid && s_axis_tready.
//  - s_axis_tready = !rst && (in_pkt || pkt_cnt < MAX_PKTS).
//    in_pkt is set on the first accepted beat and cleared on the accepted tlast beat.
//  - Each accepted byte:
//    - is written at wr_ptr (ADDR_W+1 bits, wraps modulo 2*DEPTH), then wr_ptr increments;
//    - increments len_acc (16 bits, saturating).
//  - Space check: if (wr_ptr - rd_ptr) == DEPTH, the byte is discarded, wr_ptr holds, and bad_pkt is set.
//  - When len_acc would exceed MAX_LEN, bad_pkt is set.
//  - On the accepted tlast beat:
//    - if !bad_pkt and the packet fits: push len_acc (includes the tlast byte) into the length FIFO;
//      set pkt_base = wr_ptr+1; pkt_cnt goes up by 1 on the next cycle.
//    - else: rewind wr_ptr to pkt_base; drop_cnt += 1.
//    - In both cases, clear len_acc and bad_pkt.
//  - A single-beat packet (tvalid with tlast) has length 1. Zero-length packets cannot occur.
//  Read-side FSM
//  - IDLE -> LEN_LO when pkt_cnt != 0 (1 cycle).
//  - LEN_LO: tx_tvalid=1, tx_data = len[7:0]; on tx_req -> LEN_HI.
//  - LEN_HI: tx_data = len[15:8]; on tx_req -> DATA, and load remain = len.
//  - DATA: tx_data = mem[rd_ptr] (combinational read).
//    - Each tx_req increments rd_ptr and decrements remain.
//    - On the tx_req with remain==1: pop the length FIFO, pkt_cnt -= 1, go to IDLE.
//  - tx_tvalid is 1 only in LEN_LO.
//  - tx_data is 0 in IDLE.
//  - tx_req in IDLE sets tx_underrun (sticky until rst) and is otherwise ignored.
//  - Back-to-back: the next packet's LEN_LO is reached 1 cycle after the last payload pop.
//  Timing and simultaneity
//  - FWFT latency: the byte following a pop appears on tx_data in the cycle after tx_req.
//  - Required so eth_ctrl captures the header correctly with tx_req held high for 2 cycles.
//  - Commit and release in the same cycle: pkt_cnt is unchanged and both FIFO pointers advance.
//  - Write and read in the same cycle use independent pointers.
//    The space check uses the registered rd_ptr, so freed space is visible one cycle later.
// TESTING
//  1. 4-byte pkt AA,BB,CC,DD; tx_req held 6 cycles from tx_tvalid
//     -> tx_data 04,00,AA,BB,CC,DD; pkt_cnt 1 -> 0; back to IDLE.
//  2. 300-byte pkt -> header 2C,01; eth_ctrl model forms udp_tx_byte_num=300; all 300 bytes match in order.
//  3. 1473-byte pkt, then 10-byte pkt -> drop_cnt=1; only the 10-byte pkt is presented (0A,00,...).
//  4. Fill MAX_PKTS=8 pkts with no reads -> tready=0 after 8th tlast;
//     one full read -> tready=1 within 2 cycles; 9th pkt committed.
//  5. ADDR_W=6: 40-byte pkt + 40-byte pkt, no reads -> second dropped (drop_cnt=1);
//     pointer wrap verified with 20 mixed-length pkts read back intact.
//  6. rst pulse mid-payload on both sides -> all outputs 0; next pkt after rst read back correctly.

Source files
------------

// File: rtl/eth_tx_pkt_buf.sv
// Store-and-forward TX buffer: AXI-S bytes in, committed packets out as FWFT {len_lo, len_hi, payload}.
// Packets are visible one cycle after tlast; tready drops only when the length FIFO is full between packets.
module eth_tx_pkt_buf #(
    parameter int ADDR_W  = 11,
    parameter int PKT_W   = 3,
    parameter int MAX_LEN = 1472
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic             tx_tvalid,
    input  logic             tx_req,
    output logic [7:0]       tx_data,
    output logic [PKT_W:0]   pkt_cnt,
    output logic [15:0]      drop_cnt,
    output logic             tx_underrun
);

    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int MAX_PKTS = 2 ** PKT_W;
    localparam logic [ADDR_W:0] DEPTH_P    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PKT_W:0]  MAX_PKTS_P = {1'b1, {PKT_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA} state_t;

    logic [7:0]  mem      [DEPTH];
    logic [15:0] len_fifo [MAX_PKTS];

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, pkt_base_q, pkt_base_d;
    logic [15:0]     len_acc_q, len_acc_d, remain_q, remain_d, drop_cnt_q, drop_cnt_d;
    logic            in_pkt_q, in_pkt_d, bad_pkt_q, bad_pkt_d, underrun_q, underrun_d;
    logic [PKT_W-1:0] lf_wr_q, lf_wr_d, lf_rd_q, lf_rd_d;
    logic [PKT_W:0]  pkt_cnt_q, pkt_cnt_d;
    state_t          state_q, state_d;

    logic        accept, space_full, too_long, pkt_bad, commit, mem_we, release_pkt;
    logic [15:0] len_inc, cur_len;
    logic [7:0]  tx_data_c;
    logic        tx_tvalid_c;

    assign s_axis_tready = !rst && (in_pkt_q || (pkt_cnt_q < MAX_PKTS_P));
    assign tx_tvalid     = tx_tvalid_c;
    assign tx_data       = tx_data_c;
    assign pkt_cnt       = pkt_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign tx_underrun   = underrun_q;

    // Write side: bytes land immediately, but only a good tlast makes them visible to the reader.
    always_comb begin
        accept     = s_axis_tvalid && s_axis_tready;
        space_full = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
        len_inc    = (len_acc_q == 16'hFFFF) ? len_acc_q : len_acc_q + 16'd1;
        too_long   = len_inc > 16'(MAX_LEN);
        pkt_bad    = bad_pkt_q || space_full || too_long;
        commit     = accept && s_axis_tlast && !pkt_bad;
        mem_we     = accept && !space_full;

        wr_ptr_d   = wr_ptr_q;
        pkt_base_d = pkt_base_q;
        len_acc_d  = len_acc_q;
        bad_pkt_d  = bad_pkt_q;
        in_pkt_d   = in_pkt_q;
        drop_cnt_d = drop_cnt_q;

        if (accept) begin
            if (!space_full) wr_ptr_d = wr_ptr_q + 1'b1;
            len_acc_d = len_inc;
            bad_pkt_d = pkt_bad;
            in_pkt_d  = 1'b1;
            if (s_axis_tlast) begin
                in_pkt_d  = 1'b0;
                len_acc_d = '0;
                bad_pkt_d = 1'b0;
                if (!pkt_bad) begin
                    pkt_base_d = wr_ptr_q + 1'b1;
                end else begin
                    wr_ptr_d = pkt_base_q;
                    if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
        end
    end

    // Read side: header bytes come from the length FIFO head, payload straight from RAM.
    always_comb begin
        cur_len     = len_fifo[lf_rd_q];
        state_d     = state_q;
        remain_d    = remain_q;
        rd_ptr_d    = rd_ptr_q;
        underrun_d  = underrun_q;
        release_pkt = 1'b0;
        tx_tvalid_c = 1'b0;
        tx_data_c   = 8'h00;

        unique case (state_q)
            S_IDLE: begin
                if (tx_req) underrun_d = 1'b1;
                if (pkt_cnt_q != '0) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                tx_tvalid_c = 1'b1;
                tx_data_c   = cur_len[7:0];
                if (tx_req) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                tx_data_c = cur_len[15:8];
                if (tx_req) begin
                    state_d  = S_DATA;
                    remain_d = cur_len;
                end
            end
            S_DATA: begin
                tx_data_c = mem[rd_ptr_q[ADDR_W-1:0]];
                if (tx_req) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        release_pkt = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        lf_wr_d = lf_wr_q + PKT_W'(commit);
        lf_rd_d = lf_rd_q + PKT_W'(release_pkt);
        unique case ({commit, release_pkt})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[ADDR_W-1:0]] <= s_axis_tdata;
        if (commit) len_fifo[lf_wr_q] <= len_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_base_q <= '0;
            len_acc_q  <= '0;
            remain_q   <= '0;
            drop_cnt_q <= '0;
            in_pkt_q   <= 1'b0;
            bad_pkt_q  <= 1'b0;
            underrun_q <= 1'b0;
            lf_wr_q    <= '0;
            lf_rd_q    <= '0;
            pkt_cnt_q  <= '0;
            state_q    <= S_IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_base_q <= pkt_base_d;
            len_acc_q  <= len_acc_d;
            remain_q   <= remain_d;
            drop_cnt_q <= drop_cnt_d;
            in_pkt_q   <= in_pkt_d;
            bad_pkt_q  <= bad_pkt_d;
            underrun_q <= underrun_d;
            lf_wr_q    <= lf_wr_d;
            lf_rd_q    <= lf_rd_d;
            pkt_cnt_q  <= pkt_cnt_d;
            state_q    <= state_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_pkt_buf.sv
// Bench for eth_tx_pkt_buf: a full-size and a 64-byte instance share one stimulus port, selected by sel.
module tb_eth_tx_pkt_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic [7:0] tdata;
    logic       tvalid, tlast, tx_req;

    logic       rdy_a, rdy_b, tv_a, tv_b, un_a, un_b;
    logic [7:0] d_a, d_b;
    logic [3:0] pc_a, pc_b;
    logic [15:0] dc_a, dc_b;

    logic       tready_m, tvalid_m, under_m;
    logic [7:0] data_m;
    logic [3:0] pcnt_m;
    logic [15:0] dcnt_m;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    eth_tx_pkt_buf #(.ADDR_W(11), .PKT_W(3), .MAX_LEN(1472)) u_dut_a (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid & ~sel),
        .s_axis_tlast(tlast), .s_axis_tready(rdy_a), .tx_tvalid(tv_a), .tx_req(tx_req & ~sel),
        .tx_data(d_a), .pkt_cnt(pc_a), .drop_cnt(dc_a), .tx_underrun(un_a)
    );

    eth_tx_pkt_buf #(.ADDR_W(6), .PKT_W(3), .MAX_LEN(1472)) u_dut_b (
        .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid & sel),
        .s_axis_tlast(tlast), .s_axis_tready(rdy_b), .tx_tvalid(tv_b), .tx_req(tx_req & sel),
        .tx_data(d_b), .pkt_cnt(pc_b), .drop_cnt(dc_b), .tx_underrun(un_b)
    );

    assign tready_m = sel ? rdy_b : rdy_a;
    assign tvalid_m = sel ? tv_b  : tv_a;
    assign under_m  = sel ? un_b  : un_a;
    assign data_m   = sel ? d_b   : d_a;
    assign pcnt_m   = sel ? pc_b  : pc_a;
    assign dcnt_m   = sel ? dc_b  : dc_a;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one packet; when ok is set the header and payload are queued as expected output.
    task automatic send_pkt(input int len, input logic [7:0] start, input logic [7:0] step,
                            input bit ok, input bit last_en);
        logic [7:0] b;
        logic [15:0] l16;
        int n;
        l16 = 16'(len);
        if (ok) begin
            exp_q.push_back(l16[7:0]);
            exp_q.push_back(l16[15:8]);
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            b      = start + step * 8'(i);
            tdata  = b;
            tvalid = 1'b1;
            tlast  = last_en && (i == len - 1);
            n = 0;
            while (!tready_m && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!tready_m) begin
                check_val("wr_tready", tready_m, 1'b1);
                break;
            end
            @(posedge clk);
            if (ok) exp_q.push_back(b);
        end
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic read_pkts(input int npk);
        int n, len;
        logic [7:0] got, e, olo, ohi;
        for (int k = 0; k < npk; k++) begin
            @(negedge clk);
            n = 0;
            while (!tvalid_m && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check_val("tx_tvalid", tvalid_m, 1'b1);
            if (!tvalid_m) return;
            if (exp_q.size() < 2) begin
                check_val("exp_avail", exp_q.size(), 2);
                return;
            end
            len = int'({exp_q[1], exp_q[0]});
            olo = 8'h00;
            ohi = 8'h00;
            for (int i = 0; i < len + 2; i++) begin
                if (i > 0) @(negedge clk);
                got = data_m;
                e   = exp_q.pop_front();
                check_val("tx_data", got, e);
                if (i == 0) olo = got;
                if (i == 1) begin
                    ohi = got;
                    check_val("tvalid_len_hi", tvalid_m, 1'b0);
                end
                tx_req = 1'b1;
                @(posedge clk);
            end
            @(negedge clk);
            tx_req = 1'b0;
            check_val("udp_len", {ohi, olo}, len);
        end
    endtask

    initial begin
        int n, l1, l2;
        sel = 1'b0; tdata = 8'h00; tvalid = 1'b0; tlast = 1'b0; tx_req = 1'b0; rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_tready", tready_m, 1'b0);
        check_val("rst_tvalid", tvalid_m, 1'b0);
        check_val("rst_data", data_m, 8'h00);
        check_val("rst_pkt_cnt", pcnt_m, 4'd0);
        check_val("rst_drop_cnt", dcnt_m, 16'd0);
        check_val("rst_underrun", under_m, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_val("tready_idle", tready_m, 1'b1);

        // 4-byte packet, then an underrun poke while idle
        send_pkt(4, 8'hAA, 8'h11, 1'b1, 1'b1);
        check_val("t1_pkt_cnt", pcnt_m, 4'd1);
        read_pkts(1);
        check_val("t1_pkt_cnt_done", pcnt_m, 4'd0);
        check_val("t1_idle_tvalid", tvalid_m, 1'b0);
        check_val("t1_idle_data", data_m, 8'h00);
        check_val("t1_underrun_pre", under_m, 1'b0);
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        check_val("t1_underrun", under_m, 1'b1);

        send_pkt(300, 8'h01, 8'h07, 1'b1, 1'b1);
        read_pkts(1);

        // Oversize packet is dropped, the following one goes through
        send_pkt(1473, 8'h10, 8'h03, 1'b0, 1'b1);
        send_pkt(10, 8'h50, 8'h01, 1'b1, 1'b1);
        check_val("t3_drop_cnt", dcnt_m, 16'd1);
        read_pkts(1);
        check_val("t3_exp_left", exp_q.size(), 0);

        // Length FIFO full backpressure
        for (int k = 0; k < 8; k++) send_pkt(16, 8'(k * 16), 8'h01, 1'b1, 1'b1);
        @(negedge clk);
        check_val("t4_tready_full", tready_m, 1'b0);
        check_val("t4_pkt_cnt_full", pcnt_m, 4'd8);
        read_pkts(1);
        n = 0;
        while (!tready_m && n < 2) begin
            @(negedge clk);
            n++;
        end
        check_val("t4_tready_free", tready_m, 1'b1);
        send_pkt(16, 8'hC3, 8'h05, 1'b1, 1'b1);
        check_val("t4_pkt_cnt_9th", pcnt_m, 4'd8);
        read_pkts(8);
        check_val("t4_pkt_cnt_end", pcnt_m, 4'd0);

        // Small instance: space overflow drop and pointer wrap
        sel = 1'b1;
        @(negedge clk);
        send_pkt(40, 8'h20, 8'h01, 1'b1, 1'b1);
        send_pkt(40, 8'h80, 8'h01, 1'b0, 1'b1);
        check_val("t5_drop_cnt", dcnt_m, 16'd1);
        read_pkts(1);
        for (int p = 0; p < 10; p++) begin
            l1 = int'($urandom_range(1, 30));
            l2 = int'($urandom_range(1, 30));
            send_pkt(l1, 8'($urandom), 8'($urandom_range(1, 9)), 1'b1, 1'b1);
            send_pkt(l2, 8'($urandom), 8'($urandom_range(1, 9)), 1'b1, 1'b1);
            read_pkts(2);
        end
        check_val("t5_exp_left", exp_q.size(), 0);
        check_val("t5_drop_cnt_end", dcnt_m, 16'd1);

        // Reset in the middle of both a write and a read
        sel = 1'b0;
        @(negedge clk);
        send_pkt(20, 8'h33, 8'h02, 1'b1, 1'b1);
        send_pkt(5, 8'h77, 8'h01, 1'b0, 1'b0);
        n = 0;
        while (!tvalid_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        tx_req = 1'b1;
        repeat (5) @(negedge clk);
        tx_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_tready", tready_m, 1'b0);
        check_val("t6_rst_tvalid", tvalid_m, 1'b0);
        check_val("t6_rst_data", data_m, 8'h00);
        check_val("t6_rst_pkt_cnt", pcnt_m, 4'd0);
        check_val("t6_rst_drop_cnt", dcnt_m, 16'd0);
        check_val("t6_rst_underrun", under_m, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        send_pkt(12, 8'h5A, 8'h03, 1'b1, 1'b1);
        read_pkts(1);
        check_val("t6_pkt_cnt_end", pcnt_m, 4'd0);
        check_val("t6_underrun_end", under_m, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
